fetch_pc_ctrl: RTL and testbench

- Fetch-stage PC controller that sits directly upstream of branch_predict.
- Drives the instruction-memory PC and acts on the 2-bit predict/flush word (bit0 = predict taken, bit1 = mispredict/flush).
- Per in-flight beq, records the alternate path (target or fall-through) in a 2-deep IF→ID→EX shadow pipe; on a mispredict it redirects the PC and kills wrong-path fetches.
- A fetch-only stall defers the redirect through a pending register.

---
 rtl/fe_pkg.sv | 17 +
 rtl/br_shadow_pipe.sv | 37 +++
 rtl/fetch_pc_ctrl.sv | 96 +++++++++
 tb/tb_fetch_pc_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
// Shared fetch-stage definitions: default reset PC, beq opcode and the
// branch shadow entry that travels IF->ID->EX with each in-flight beq.
package fe_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [5:0]  BEQ_OPCODE_DEF = 6'd4;
    localparam int unsigned INSN_BYTES     = 4;

    // Alternate path of an in-flight beq: where fetch must go if the
    // prediction made in IF turns out wrong in EX.
    typedef struct packed {
        logic        valid;
        logic        pred;
        logic [31:0] alt;
    } br_shadow_t;

endpackage

// File: rtl/br_shadow_pipe.sv
// Two-deep shadow pipe (D then E) holding the alternate fetch path of
// each beq as it moves through ID and EX.
module br_shadow_pipe
    import fe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kill,
    input  logic       stall,
    input  br_shadow_t d_in,
    output br_shadow_t e_out
);

    br_shadow_t d_q;
    br_shadow_t e_q;

    // Advance D->E every cycle; a fetch stall leaves a bubble in D, a kill
    // invalidates both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= '0;
            e_q <= '0;
        end else if (kill) begin
            d_q.valid <= 1'b0;
            e_q.valid <= 1'b0;
        end else if (!stall) begin
            e_q <= d_q;
            d_q <= d_in;
        end else begin
            e_q       <= d_q;
            d_q.valid <= 1'b0;
        end
    end

    assign e_out = e_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: sequential/predicted next PC, mispredict
// recovery from the shadow pipe, and stall-deferred redirect.
module fetch_pc_ctrl
    import fe_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [5:0]  BEQ_OPCODE = BEQ_OPCODE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        istall,
    input  logic [31:0] iInstruction,
    input  logic [1:0]  ibp_predict,
    output logic [31:0] opc,
    output logic        oflush_IF,
    output logic        oflush_ID,
    output logic        oredirect
);

    logic        beq_if;
    logic [31:0] pc4;
    logic [31:0] target;
    logic        mispredict;
    logic        pending_valid;
    logic [31:0] pending_addr;
    logic [31:0] pc_next;
    logic        pending_valid_next;
    logic [31:0] pending_addr_next;
    logic        redirect;
    br_shadow_t  d_in;
    br_shadow_t  e_entry;

    assign beq_if     = (iInstruction[31:26] == BEQ_OPCODE);
    assign pc4        = opc + 32'(INSN_BYTES);
    assign target     = pc4 + {{14{iInstruction[15]}}, iInstruction[15:0], 2'b00};
    assign mispredict = ibp_predict[1] & e_entry.valid;

    // New shadow entries are suppressed while a redirect is pending: the
    // instructions being fetched then are all on the wrong path.
    assign d_in.valid = beq_if & ~pending_valid;
    assign d_in.pred  = ibp_predict[0];
    assign d_in.alt   = ibp_predict[0] ? pc4 : target;

    br_shadow_pipe u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .kill  (mispredict),
        .stall (istall),
        .d_in  (d_in),
        .e_out (e_entry)
    );

    // Next-PC priority mux: recovery first, then pending redirect, stall,
    // predicted-taken target, sequential.
    always_comb begin
        pc_next            = opc;
        pending_valid_next = pending_valid;
        pending_addr_next  = pending_addr;
        redirect           = 1'b0;
        if (mispredict && !istall) begin
            pc_next  = e_entry.alt;
            redirect = 1'b1;
        end else if (mispredict) begin
            pending_valid_next = 1'b1;
            pending_addr_next  = e_entry.alt;
        end else if (pending_valid && !istall) begin
            pc_next            = pending_addr;
            pending_valid_next = 1'b0;
            redirect           = 1'b1;
        end else if (istall) begin
            pc_next = opc;
        end else if (beq_if && ibp_predict[0] && !pending_valid) begin
            pc_next = target;
        end else begin
            pc_next = pc4;
        end
    end

    // PC and pending-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc           <= RESET_PC;
            pending_valid <= 1'b0;
            pending_addr  <= '0;
        end else begin
            opc           <= pc_next;
            pending_valid <= pending_valid_next;
            pending_addr  <= pending_addr_next;
        end
    end

    assign oredirect = redirect;
    assign oflush_IF = redirect;
    assign oflush_ID = mispredict;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios plus random
// traffic, all compared against an in-bench model of in-flight branches.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        istall = 1'b0;
    logic [31:0] iInstruction = '0;
    logic [1:0]  ibp_predict = '0;
    logic [31:0] opc;
    logic        oflush_IF, oflush_ID, oredirect;

    int checks = 0;
    int errors = 0;

    fetch_pc_ctrl #(.RESET_PC(32'h0000_0000), .BEQ_OPCODE(6'd4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .istall       (istall),
        .iInstruction (iInstruction),
        .ibp_predict  (ibp_predict),
        .opc          (opc),
        .oflush_IF    (oflush_IF),
        .oflush_ID    (oflush_ID),
        .oredirect    (oredirect)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Model: PC, pending redirect, and a list of in-flight beqs tagged by stage
    // (1 = ID, 2 = EX).
    typedef struct {
        logic [31:0] alt;
        int          stage;
    } fl_t;

    fl_t         inflight[$];
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_paddr;
    logic        s_fid, s_fif, s_red;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] insn);
        logic signed [31:0] off;
        off = 32'(signed'(insn[15:0])) * 4;
        return pc + 32'd4 + off;
    endfunction

    function automatic logic [31:0] mk_beq(input logic [15:0] imm);
        logic [9:0] regs;
        regs = 10'($urandom);
        return {6'd4, regs, imm};
    endfunction

    function automatic logic [31:0] mk_other();
        logic [5:0]  op;
        logic [31:0] r;
        op = 6'($urandom);
        if (op == 6'd4) op = 6'd0;
        r = $urandom;
        return {op, r[25:0]};
    endfunction

    task automatic model_reset();
        inflight.delete();
        m_pc    = 32'h0;
        m_pend  = 1'b0;
        m_paddr = 32'h0;
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic st, input logic [31:0] insn, input logic [1:0] bp);
        logic        e_here, is_beq, mp, red;
        logic [31:0] e_alt, next_pc;
        fl_t         nq[$];
        istall       = st;
        iInstruction = insn;
        ibp_predict  = bp;
        @(negedge clk);
        e_here = 1'b0;
        e_alt  = '0;
        foreach (inflight[i]) if (inflight[i].stage == 2) begin
            e_here = 1'b1;
            e_alt  = inflight[i].alt;
        end
        is_beq = (insn[31:26] == 6'd4);
        mp     = bp[1] & e_here;
        red    = (mp & ~st) | (~mp & m_pend & ~st);
        if (mp && m_pend) begin
            errors++;
            $display("FAIL mp_while_pending: got 1 expected 0 (t=%0t)", $time);
        end
        chk("opc", opc, m_pc);
        chk("oflush_ID", 32'(oflush_ID), 32'(mp));
        chk("oflush_IF", 32'(oflush_IF), 32'(red));
        chk("oredirect", 32'(oredirect), 32'(red));
        s_fid = oflush_ID;
        s_fif = oflush_IF;
        s_red = oredirect;
        next_pc = m_pc;
        if (mp && !st) next_pc = e_alt;
        else if (mp) begin
            m_pend  = 1'b1;
            m_paddr = e_alt;
        end else if (m_pend && !st) begin
            next_pc = m_paddr;
            m_pend  = 1'b0;
        end else if (st) next_pc = m_pc;
        else if (is_beq && bp[0]) next_pc = branch_target(m_pc, insn);
        else next_pc = m_pc + 32'd4;
        if (mp) inflight.delete();
        else begin
            foreach (inflight[i]) if (inflight[i].stage == 1) nq.push_back('{inflight[i].alt, 2});
            if (!st && is_beq && !(m_pend && !red && !mp) && !(red && !mp && !st)) begin
                // an entry is created only when no redirect was pending at fetch
                nq.push_back('{(bp[0] ? m_pc + 32'd4 : branch_target(m_pc, insn)), 1});
            end
            inflight = nq;
        end
        m_pc = next_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_opc", opc, 32'h0);
        chk("rst_flush_ID", 32'(oflush_ID), 32'h0);
        chk("rst_flush_IF", 32'(oflush_IF), 32'h0);
        chk("rst_redirect", 32'(oredirect), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic nop();
        step(1'b0, mk_other(), 2'b00);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // 1: sequential fetch
        chk("t1_opc0", opc, 32'h0);
        nop(); chk("t1_opc4", opc, 32'h4);
        nop(); chk("t1_opc8", opc, 32'h8);
        nop(); chk("t1_opcC", opc, 32'hC);
        nop(); chk("t1_opc10", opc, 32'h10);

        // 2: predicted-taken beq, then mispredict from EX
        step(1'b0, mk_beq(16'h0003), 2'b01); chk("t2_target", opc, 32'h20);
        nop();                               chk("t2_seq", opc, 32'h24);
        step(1'b0, mk_other(), 2'b10);
        chk("t2_flushID", 32'(s_fid), 32'h1);
        chk("t2_flushIF", 32'(s_fif), 32'h1);
        chk("t2_redirect", 32'(s_red), 32'h1);
        chk("t2_recover", opc, 32'h14);

        // 3: backward beq predicted not-taken
        for (int unsigned i = 0; i < 11; i++) nop();
        chk("t3_at40", opc, 32'h40);
        step(1'b0, mk_beq(16'hFFFE), 2'b00); chk("t3_44", opc, 32'h44);
        nop();                               chk("t3_48", opc, 32'h48);
        step(1'b0, mk_other(), 2'b10);       chk("t3_recover", opc, 32'h3C);

        // 4: mispredict during a 3-cycle stall
        step(1'b0, mk_beq(16'h0002), 2'b01); chk("t4_target", opc, 32'h48);
        nop();                               chk("t4_4C", opc, 32'h4C);
        step(1'b1, mk_other(), 2'b10);
        chk("t4_detect_fid", 32'(s_fid), 32'h1);
        chk("t4_detect_red", 32'(s_red), 32'h0);
        chk("t4_hold0", opc, 32'h4C);
        step(1'b1, mk_other(), 2'b00);       chk("t4_hold1", opc, 32'h4C);
        step(1'b1, mk_other(), 2'b00);       chk("t4_hold2", opc, 32'h4C);
        step(1'b0, mk_other(), 2'b00);
        chk("t4_release_fif", 32'(s_fif), 32'h1);
        chk("t4_recover", opc, 32'h40);
        nop();                               chk("t4_cleared", opc, 32'h44);

        // 5: wrap past the top of the address space
        step(1'b0, mk_beq(16'hFFEC), 2'b01); chk("t5_high", opc, 32'hFFFF_FFF8);
        step(1'b0, mk_beq(16'h0001), 2'b01); chk("t5_wrap", opc, 32'h0000_0000);
        nop();
        nop();

        // 6: reset while a redirect is pending
        step(1'b0, mk_beq(16'h0005), 2'b00);
        nop();
        step(1'b1, mk_other(), 2'b10);
        do_reset();
        step(1'b0, mk_other(), 2'b10);
        chk("t6_no_flush", 32'(s_fid), 32'h0);
        chk("t6_no_redirect", 32'(s_red), 32'h0);
        chk("t6_opc", opc, 32'h4);

        // Random traffic
        for (int unsigned n = 0; n < 3000; n++) begin
            logic        st;
            logic [31:0] insn;
            logic [1:0]  bp;
            if ($urandom_range(0, 299) == 0) do_reset();
            st   = ($urandom_range(0, 3) == 0);
            insn = ($urandom_range(0, 9) < 3) ? mk_beq(16'($urandom)) : mk_other();
            bp   = {($urandom_range(0, 9) < 3), 1'($urandom)};
            step(st, insn, bp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
